// File: rtl/uart_fifo_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_cmd_ctrl
// Description : Single-byte ASCII command sequencer between a UART and a byte
//               FIFO. Decodes W/R/C/D commands, issues push/pop strobes,
//               tracks FIFO occupancy and serialises response bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_cmd_ctrl #(
  parameter int         DEPTH    = 16,
  parameter int         CNT_W    = 8,
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] NAK_BYTE = 8'h15,
  parameter logic [7:0] ACK_BYTE = 8'h06
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  input  logic             i_tx_busy,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  output logic             o_fifo_wr_en,
  output logic [7:0]       o_fifo_wr_data,
  output logic             o_fifo_rd_en,
  input  logic [7:0]       i_fifo_rd_data,
  output logic [CNT_W-1:0] o_fifo_count,
  output logic             o_fifo_full,
  output logic             o_fifo_empty,
  output logic             o_cmd_err
);

  localparam logic [7:0] C_CMD_W = 8'h57;
  localparam logic [7:0] C_CMD_R = 8'h52;
  localparam logic [7:0] C_CMD_C = 8'h43;
  localparam logic [7:0] C_CMD_D = 8'h44;

  localparam int                 C_TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   C_DEPTH    = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GET_DATA   = 3'd1,
    S_POP_RD     = 3'd2,
    S_POP_CAP    = 3'd3,
    S_SEND       = 3'd4,
    S_SEND_GUARD = 3'd5,
    S_SEND_WAIT  = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_wr_en;
  logic [7:0]         r_wr_data;
  logic               r_rd_en;
  logic [7:0]         r_tx_data;
  logic               r_cmd_err;
  logic               r_drain;
  logic [C_TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0]   r_count;
  logic               r_full;
  logic               r_empty;

  logic               w_push;
  logic               w_pop;
  logic               w_err;
  logic               w_tx_start;
  logic [7:0]         w_tx_nxt;
  logic               w_drain_nxt;
  logic [C_TMO_W-1:0] w_tmo_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [7:0]         w_count8;

  // Occupancy as a byte: zero-extend narrow counters, truncate wide ones.
  generate
    if (CNT_W >= 8) begin : g_cnt8_trunc
      assign w_count8 = r_count[7:0];
    end else begin : g_cnt8_ext
      assign w_count8 = {{(8 - CNT_W){1'b0}}, r_count};
    end
  endgenerate

  // Push and pop are mutually exclusive, and each is gated by full/empty.
  assign w_count_nxt = w_push ? (r_count + CNT_W'(1)) :
                       w_pop  ? (r_count - CNT_W'(1)) : r_count;

  // Next-state, strobe and response-byte decode.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err       = 1'b0;
    w_tx_start  = 1'b0;
    w_tx_nxt    = r_tx_data;
    w_drain_nxt = r_drain;
    w_tmo_nxt   = r_tmo;

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            C_CMD_W: begin
              // Count the 'W' cycle itself so the timeout fires TIMEOUT clocks later.
              w_tmo_nxt   = C_TMO_W'(1);
              w_state_nxt = S_GET_DATA;
            end
            C_CMD_R: begin
              if (r_empty) begin
                w_tx_nxt    = NAK_BYTE;
                w_state_nxt = S_SEND;
              end else begin
                w_pop       = 1'b1;
                w_state_nxt = S_POP_RD;
              end
            end
            C_CMD_C: begin
              w_tx_nxt    = w_count8;
              w_state_nxt = S_SEND;
            end
            C_CMD_D: begin
              w_tx_nxt    = w_count8;
              w_drain_nxt = 1'b1;
              w_state_nxt = S_SEND;
            end
            default: begin
              w_err       = 1'b1;
              w_tx_nxt    = NAK_BYTE;
              w_state_nxt = S_SEND;
            end
          endcase
        end
      end

      S_GET_DATA: begin
        if (i_rx_valid) begin
          if (!r_full) begin
            w_push   = 1'b1;
            w_tx_nxt = ACK_BYTE;
          end else begin
            w_tx_nxt = NAK_BYTE;
          end
          w_state_nxt = S_SEND;
        end else if (r_tmo >= C_TMO_LAST) begin
          w_err       = 1'b1;
          w_tx_nxt    = NAK_BYTE;
          w_state_nxt = S_SEND;
        end else begin
          w_tmo_nxt = r_tmo + C_TMO_W'(1);
        end
      end

      // Pop strobe is on the wire this cycle; FIFO data arrives next cycle.
      S_POP_RD: w_state_nxt = S_POP_CAP;

      S_POP_CAP: begin
        w_tx_nxt    = i_fifo_rd_data;
        w_state_nxt = S_SEND;
      end

      S_SEND: begin
        if (!i_tx_busy) begin
          w_tx_start  = 1'b1;
          w_state_nxt = S_SEND_GUARD;
        end
      end

      // Transmitter raises busy one cycle after start; ignore it meanwhile.
      S_SEND_GUARD: w_state_nxt = S_SEND_WAIT;

      S_SEND_WAIT: begin
        if (!i_tx_busy) begin
          if (r_drain && !r_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_POP_RD;
          end else begin
            w_drain_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // A byte that arrives while popping or sending cannot be serviced.
    if (i_rx_valid && (r_state != S_IDLE) && (r_state != S_GET_DATA)) begin
      w_err = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered strobes, response byte, timeout and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
      r_rd_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_cmd_err <= 1'b0;
      r_drain   <= 1'b0;
      r_tmo     <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
    end else begin
      r_wr_en   <= w_push;
      if (w_push) begin
        r_wr_data <= i_rx_data;
      end
      r_rd_en   <= w_pop;
      r_tx_data <= w_tx_nxt;
      r_cmd_err <= w_err;
      r_drain   <= w_drain_nxt;
      r_tmo     <= w_tmo_nxt;
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == C_DEPTH);
      r_empty   <= (w_count_nxt == '0);
    end
  end

  assign o_tx_start     = w_tx_start;
  assign o_tx_data      = r_tx_data;
  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_wr_data = r_wr_data;
  assign o_fifo_rd_en   = r_rd_en;
  assign o_fifo_count   = r_count;
  assign o_fifo_full    = r_full;
  assign o_fifo_empty   = r_empty;
  assign o_cmd_err      = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_cmd_ctrl
// Description : Directed self-checking bench for uart_fifo_cmd_ctrl with a
//               behavioural UART transmitter and byte FIFO around the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_cmd_ctrl;

  localparam int C_TIMEOUT = 50;
  localparam int C_FRAME   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       w_tx_busy;
  logic       w_tx_start;
  logic [7:0] w_tx_data;
  logic       w_wr_en;
  logic [7:0] w_wr_data;
  logic       w_rd_en;
  logic [7:0] r_rd_data;
  logic [7:0] w_count;
  logic       w_full;
  logic       w_empty;
  logic       w_cmd_err;

  logic       r_force_busy;
  int         r_busy_cnt = 0;
  int         r_cyc      = 0;
  int         n_wr = 0, n_rd = 0, n_err = 0, n_viol = 0, n_under = 0;
  logic [7:0] txq[$];
  logic [7:0] fq[$];

  int n_vec = 0;
  int n_bad = 0;

  uart_fifo_cmd_ctrl #(
    .DEPTH   (16),
    .CNT_W   (8),
    .TIMEOUT (C_TIMEOUT),
    .NAK_BYTE(8'h15),
    .ACK_BYTE(8'h06)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx_valid    (r_rx_valid),
    .i_rx_data     (r_rx_data),
    .i_tx_busy     (w_tx_busy),
    .o_tx_start    (w_tx_start),
    .o_tx_data     (w_tx_data),
    .o_fifo_wr_en  (w_wr_en),
    .o_fifo_wr_data(w_wr_data),
    .o_fifo_rd_en  (w_rd_en),
    .i_fifo_rd_data(r_rd_data),
    .o_fifo_count  (w_count),
    .o_fifo_full   (w_full),
    .o_fifo_empty  (w_empty),
    .o_cmd_err     (w_cmd_err)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurement.
  always @(posedge clk) r_cyc <= r_cyc + 1;

  // UART transmitter: busy for C_FRAME clocks starting the cycle after start.
  always @(posedge clk) begin
    if (w_tx_start)          r_busy_cnt <= C_FRAME;
    else if (r_busy_cnt > 0) r_busy_cnt <= r_busy_cnt - 1;
  end
  assign w_tx_busy = (r_busy_cnt != 0) || r_force_busy;

  // Byte FIFO: read data is valid the cycle after the pop strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      r_rd_data <= 8'h00;
    end else begin
      if (w_wr_en) fq.push_back(w_wr_data);
      if (w_rd_en) begin
        if (fq.size() == 0) n_under <= n_under + 1;
        else                r_rd_data <= fq.pop_front();
      end
    end
  end

  // Observe DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (w_tx_start) begin
      txq.push_back(w_tx_data);
      if (w_tx_busy) n_viol <= n_viol + 1;
    end
    if (w_wr_en)   n_wr  <= n_wr + 1;
    if (w_rd_en)   n_rd  <= n_rd + 1;
    if (w_cmd_err) n_err <= n_err + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    r_rx_valid = 1'b1;
    r_rx_data  = b;
    @(negedge clk);
    r_rx_valid = 1'b0;
  endtask

  task automatic wait_tx_cnt(input int n, input string tag);
    for (int i = 0; i < 3000 && txq.size() < n; i++) @(negedge clk);
    check_val(tag, txq.size(), n);
  endtask

  task automatic wait_tx(input int n, input string tag);
    wait_tx_cnt(n, tag);
    repeat (C_FRAME + 4) @(negedge clk);
  endtask

  task automatic wr_cmd(input logic [7:0] b, input string tag);
    int n;
    n = txq.size() + 1;
    send(8'h57);
    repeat (2) @(negedge clk);
    send(b);
    wait_tx(n, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_flags"}, {w_tx_start, w_wr_en, w_rd_en, w_full, w_empty, w_cmd_err}, 6'b000010);
    check_val({tag, "_txd"}, w_tx_data, 8'h00);
    check_val({tag, "_wrd"}, w_wr_data, 8'h00);
    check_val({tag, "_cnt"}, w_count, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txq.delete();
  endtask

  // Directed scenarios.
  initial begin
    int b_rd, b_err, b_wr, t0, t1;
    logic [7:0] e3 [7];
    logic [7:0] e5 [5];

    r_rx_valid   = 1'b0;
    r_rx_data    = 8'h00;
    r_force_busy = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: strobe one clock after the data byte.
    send(8'h57);
    repeat (2) @(negedge clk);
    send(8'hA5);
    check_val("w_wr_en", w_wr_en, 1'b1);
    check_val("w_wr_data", w_wr_data, 8'hA5);
    check_val("w_count", w_count, 8'd1);
    check_val("w_empty", w_empty, 1'b0);
    wait_tx(1, "w_txn");
    check_val("w_ack", txq[0], 8'h06);

    // Two writes, three reads; the last read is refused.
    do_reset();
    wr_cmd(8'h11, "rw_w1");
    wr_cmd(8'h22, "rw_w2");
    b_rd = n_rd;
    send(8'h52); wait_tx(3, "rw_r1");
    send(8'h52); wait_tx(4, "rw_r2");
    send(8'h52); wait_tx(5, "rw_r3");
    check_val("rw_b2", txq[2], 8'h11);
    check_val("rw_b3", txq[3], 8'h22);
    check_val("rw_nak", txq[4], 8'h15);
    check_val("rw_npop", n_rd - b_rd, 2);
    check_val("rw_cnt", w_count, 8'd0);

    // Fill to DEPTH, then one more write is refused.
    do_reset();
    for (int i = 0; i < 16; i++) wr_cmd(8'(i), "fill_w");
    check_val("fill_full", w_full, 1'b1);
    check_val("fill_cnt", w_count, 8'd16);
    b_wr = n_wr;
    wr_cmd(8'hFF, "ovf_w");
    check_val("ovf_nak", txq[16], 8'h15);
    check_val("ovf_cnt", w_count, 8'd16);
    check_val("ovf_nopush", n_wr - b_wr, 0);

    // Three entries then drain.
    do_reset();
    for (int i = 1; i <= 3; i++) wr_cmd(8'(i), "d_w");
    b_rd = n_rd;
    send(8'h44);
    wait_tx(7, "d_txn");
    e3 = '{8'h06, 8'h06, 8'h06, 8'h03, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 7; i++) check_val("d_byte", txq[i], e3[i]);
    check_val("d_npop", n_rd - b_rd, 3);
    check_val("d_empty", w_empty, 1'b1);

    // Unknown command.
    txq.delete();
    b_err = n_err;
    send(8'h58);
    check_val("x_err_hi", w_cmd_err, 1'b1);
    @(negedge clk);
    check_val("x_err_lo", w_cmd_err, 1'b0);
    wait_tx(1, "x_txn");
    check_val("x_nak", txq[0], 8'h15);

    // Write with no data: W is clock 0, cmd_err is visible in clock TIMEOUT,
    // i.e. TIMEOUT-1 rising edges after the edge that sampled 'W'.
    txq.delete();
    b_wr = n_wr;
    send(8'h57);
    t0 = r_cyc;
    t1 = t0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (w_cmd_err) begin
        t1 = r_cyc;
        break;
      end
    end
    check_val("tmo_delay", t1 - t0, C_TIMEOUT - 1);
    wait_tx(1, "tmo_txn");
    check_val("tmo_nak", txq[0], 8'h15);
    check_val("tmo_nopush", n_wr - b_wr, 0);
    send(8'h43);
    wait_tx(2, "tmo_idle");
    check_val("tmo_cnt", txq[1], 8'h00);

    // Drain under a long busy hold with a byte dropped mid-drain.
    do_reset();
    for (int i = 10; i <= 13; i++) wr_cmd(8'(i), "s_w");
    txq.delete();
    b_rd  = n_rd;
    b_err = n_err;
    send(8'h44);
    wait_tx_cnt(2, "s_first");
    r_force_busy = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h5A);
    check_val("s_drop_err", w_cmd_err, 1'b1);
    repeat (200) @(negedge clk);
    check_val("s_hold", txq.size(), 2);
    r_force_busy = 1'b0;
    wait_tx(5, "s_txn");
    e5 = '{8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    for (int i = 0; i < 5; i++) check_val("s_byte", txq[i], e5[i]);
    check_val("s_npop", n_rd - b_rd, 4);
    check_val("s_nerr", n_err - b_err, 1);
    check_val("s_empty", w_empty, 1'b1);

    // Reset in the middle of a drain.
    do_reset();
    wr_cmd(8'h01, "m_w");
    wr_cmd(8'h02, "m_w");
    txq.delete();
    b_rd = n_rd;
    send(8'h44);
    wait_tx_cnt(2, "m_first");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("m_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("m_notx", txq.size(), 2);
    check_val("m_npop", n_rd - b_rd, 1);
    send(8'h43);
    wait_tx(3, "m_c");
    check_val("m_cnt", txq[2], 8'h00);

    check_val("start_while_busy", n_viol, 0);
    check_val("fifo_underflow", n_under, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_fifo_cmd_ctrl.md
Name: uart_fifo_cmd_ctrl

Overview:
- Command sequencer between the UART (rx_valid/rx_data, tx_start/tx_data) and the byte FIFO (enable_write/enable_read).
- Decodes single-byte ASCII commands received over UART, then issues FIFO push/pop strobes and serialises response bytes to the UART transmitter.
- Tracks FIFO occupancy itself so that overflow and underflow are refused with a NAK byte.
- Replaces the ad-hoc service glue; the FIFO and UART instances remain unchanged.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..128.
- CNT_W, 8, occupancy counter width; must satisfy 2^CNT_W > DEPTH.
- TIMEOUT, 1000000, clocks allowed between 'W' and its data byte.
- NAK_BYTE, 8'h15, refusal/error response.
- ACK_BYTE, 8'h06, successful-write response.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  UART transmitter busy; rises the cycle after tx_start and falls at end of frame.
- tx_start  out  1  one-cycle strobe to launch a frame.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls.
- fifo_wr_en  out  1  one-cycle push strobe.
- fifo_wr_data  out  8  push data; valid while fifo_wr_en is high.
- fifo_rd_en  out  1  one-cycle pop strobe.
- fifo_rd_data  in  8  pop data, valid the cycle after fifo_rd_en.
- fifo_count  out  CNT_W  current occupancy.
- fifo_full  out  1  fifo_count == DEPTH.
- fifo_empty  out  1  fifo_count == 0.
- cmd_err  out  1  one-cycle pulse on bad command, timeout, or dropped byte.

Behaviour:
- Reset value of every output is 0, except fifo_empty = 1. State resets to IDLE and the counter to 0. The FIFO shares this reset.
- Commands accepted in IDLE:
  - 'W' (8'h57): go to GET_DATA.
  - 'R' (8'h52): pop one byte and transmit it.
  - 'C' (8'h43): transmit fifo_count, zero-extended/truncated to 8 bits.
  - 'D' (8'h44): transmit fifo_count, then pop and transmit every entry until empty.
  - Any other byte: pulse cmd_err and transmit NAK_BYTE.
- GET_DATA:
  - The next rx_valid byte is data. If not full: fifo_wr_en = 1 with fifo_wr_data = byte, exactly 1 cycle after the rx_valid cycle, then transmit ACK_BYTE. If full: byte discarded, transmit NAK_BYTE.
  - The timeout counter starts on 'W'. If TIMEOUT clocks pass with no byte: cmd_err pulse, NAK_BYTE, return to IDLE.
- POP ('R', or each 'D' iteration):
  - Empty at 'R': transmit NAK_BYTE, no fifo_rd_en.
  - Otherwise: fifo_rd_en at cycle t. fifo_rd_data is captured into tx_data at t+1. tx_start is raised at t+2, or at the first later cycle with tx_busy = 0.
  - 'D' with an empty FIFO transmits only the count byte (8'h00).
- SEND:
  - tx_start is raised only when tx_busy = 0.
  - Next state is SEND_GUARD (1 cycle, tx_busy ignored), then SEND_WAIT until tx_busy = 0.
  - Afterwards: return to IDLE, or back to POP while a drain is active and the FIFO is not empty.
- Occupancy:
  - +1 on fifo_wr_en, -1 on fifo_rd_en. The two are never asserted in the same cycle.
  - The counter saturates by construction: no push when full, no pop when empty.
  - fifo_full and fifo_empty are registered and update in the same cycle as fifo_count.
- Bytes arriving outside IDLE/GET_DATA (during POP/SEND states) are dropped with a cmd_err pulse. State is unaffected.
- Reset asserted mid-command aborts immediately: no pending strobe completes. After release, the block is in IDLE and waits for a new command byte.
- Latency from the command rx_valid to the first tx_start is at most 4 clocks when tx_busy = 0.

Test Plan:
- 'W',8'hA5 → fifo_wr_en 1 clk after the data rx_valid with wr_data = A5; tx_data = 06; fifo_count 0→1; fifo_empty falls.
- 'W',11, 'W',22, 'R', 'R', 'R' → transmitted 06, 06, 11, 22, 15; count returns to 0; no third fifo_rd_en.
- Fill 16 entries via 'W', then 'W',8'hFF → fifo_full = 1; 17th byte refused with 15; count stays 16.
- 3 entries (01,02,03) then 'D' → transmitted 03, 01, 02, 03; exactly 3 fifo_rd_en pulses; fifo_empty = 1 at end.
- 'X' → cmd_err pulse, tx 15. 'W' with TIMEOUT=50 and no data → cmd_err at clock 50, tx 15, IDLE.
- tx_busy held high 200 clks during a 'D' drain, plus an rx byte injected mid-drain and rst_n pulsed low mid-drain → no lost or duplicated bytes; dropped byte gives cmd_err; reset forces all outputs to reset values, count 0.
